// File: rtl/reg_file_arbiter_if.sv
// Requester-side bus of the register file arbiter: per-requester request
// slices going in, one-hot grant and shared read data coming back.
interface reg_file_arbiter_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int REG_BIT_CNT = 3,
    parameter int NUM_REQ     = 3
);
    // Handshake: a requester holds req[i] (with its we/sel/wdata slice stable)
    // until it sees gnt[i] high in the same cycle; that cycle is the access.
    // rdata is valid in the grant cycle, a write commits on the next clk edge.
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ*REG_BIT_CNT-1:0] req_sel;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]             gnt;
    logic [DATA_WIDTH-1:0]          rdata;

    modport master (
        output req, req_we, req_sel, req_wdata,
        input  gnt, rdata
    );

    modport slave (
        input  req, req_we, req_sel, req_wdata,
        output gnt, rdata
    );
endinterface

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter in front of a single-port register file, with a
// sequenced zero-fill of every register after reset and on clear_req.
module reg_file_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int REG_BIT_CNT = 3,
    parameter int NUM_REQ     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_req,
    output logic                   clear_busy,
    reg_file_arbiter_if.slave      bus,
    output logic                   rf_we,
    output logic [REG_BIT_CNT-1:0] rf_sel,
    output logic [DATA_WIDTH-1:0]  rf_acc,
    input  logic [DATA_WIDTH-1:0]  rf_data_out,
    output logic                   dbg_clearing
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [REG_BIT_CNT:0] LAST_REG = (REG_BIT_CNT+1)'((1 << REG_BIT_CNT) - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [REG_BIT_CNT:0] cnt, cnt_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [PTR_W-1:0]     win;
    logic                 found;
    logic [NUM_REQ-1:0]   gnt_c;
    int                   idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ptr_nxt    = ptr;
        gnt_c      = '0;
        rf_we      = 1'b0;
        rf_sel     = '0;
        rf_acc     = '0;
        clear_busy = 1'b0;
        found      = 1'b0;
        win        = '0;
        idx        = 0;

        // First asserted request at or after ptr, wrapping modulo NUM_REQ.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end

        case (state)
            S_CLEAR: begin
                clear_busy = 1'b1;
                rf_we      = 1'b1;
                rf_sel     = cnt[REG_BIT_CNT-1:0];
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST_REG) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end else if (found) begin
                    gnt_c[win] = 1'b1;
                    rf_we      = bus.req_we[win];
                    rf_sel     = bus.req_sel[int'(win)*REG_BIT_CNT +: REG_BIT_CNT];
                    rf_acc     = bus.req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    ptr_nxt    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign bus.gnt      = gnt_c;
    assign bus.rdata    = rf_data_out;
    assign dbg_clearing = (state == S_CLEAR);
endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed vector table, hand sequences for clear
// and reset corners, and random traffic checked against a behavioural model.
module tb_reg_file_arbiter;
  localparam int DW = 8;
  localparam int RB = 3;
  localparam int N  = 3;
  localparam int NREG = 1 << RB;

  logic clk = 1'b0;
  logic rst;
  logic clear_req;
  logic clear_busy;
  logic rf_we;
  logic [RB-1:0] rf_sel;
  logic [DW-1:0] rf_acc;
  logic [DW-1:0] rf_data_out;
  logic dbg_clearing;

  reg_file_arbiter_if #(.DATA_WIDTH(DW), .REG_BIT_CNT(RB), .NUM_REQ(N)) bus ();

  reg_file_arbiter #(.DATA_WIDTH(DW), .REG_BIT_CNT(RB), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
    .bus(bus), .rf_we(rf_we), .rf_sel(rf_sel), .rf_acc(rf_acc),
    .rf_data_out(rf_data_out), .dbg_clearing(dbg_clearing)
  );

  always #5 clk = ~clk;

  // register file the arbiter drives
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_we) rf_mem[rf_sel] <= rf_acc;
  assign rf_data_out = rf_mem[rf_sel];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] m_regs [NREG];
  int m_left;
  int m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_check();
    int w;
    int s;
    if (rst) begin
      m_left = NREG;
      m_ptr = 0;
    end
    if (m_left > 0) begin
      chk("m_busy", clear_busy, 1);
      chk("m_gnt", bus.gnt, 0);
      chk("m_we", rf_we, 1);
      chk("m_sel", rf_sel, NREG - m_left);
      chk("m_acc", rf_acc, 0);
    end else begin
      chk("m_busy", clear_busy, 0);
      if (clear_req) begin
        chk("m_gnt", bus.gnt, 0);
        chk("m_we", rf_we, 0);
      end else begin
        w = m_winner();
        if (w < 0) begin
          chk("m_gnt", bus.gnt, 0);
          chk("m_we", rf_we, 0);
          chk("m_sel", rf_sel, 0);
          chk("m_acc", rf_acc, 0);
          chk("m_rdata", bus.rdata, m_regs[0]);
        end else begin
          s = int'(bus.req_sel[w*RB +: RB]);
          chk("m_gnt", bus.gnt, 1 << w);
          chk("m_we", rf_we, bus.req_we[w]);
          chk("m_sel", rf_sel, s);
          chk("m_acc", rf_acc, bus.req_wdata[w*DW +: DW]);
          chk("m_rdata", bus.rdata, m_regs[s]);
        end
      end
    end
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      m_left = NREG;
      m_ptr = 0;
      m_regs[0] = '0;
    end else if (m_left > 0) begin
      m_regs[NREG - m_left] = '0;
      m_left--;
    end else if (clear_req) begin
      m_left = NREG;
    end else begin
      w = m_winner();
      if (w >= 0) begin
        if (bus.req_we[w]) m_regs[bus.req_sel[w*RB +: RB]] = bus.req_wdata[w*DW +: DW];
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] we,
                       input logic [N*RB-1:0] sel, input logic [N*DW-1:0] wd);
    bus.req = r;
    bus.req_we = we;
    bus.req_sel = sel;
    bus.req_wdata = wd;
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*RB-1:0] sel;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    exp_gnt;
    logic            exp_we;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'b010, 3'b010, {3'd0, 3'd5, 3'd0}, {8'h00, 8'hA5, 8'h00}, 3'b010, 1'b1, 8'h00});
    vecs.push_back('{3'b001, 3'b000, {3'd0, 3'd0, 3'd5}, 24'h0,                   3'b001, 1'b0, 8'hA5});
    vecs.push_back('{3'b000, 3'b000, 9'd0,               24'h0,                   3'b000, 1'b0, 8'h00});
    vecs.push_back('{3'b010, 3'b000, {3'd0, 3'd3, 3'd0}, 24'h0,                   3'b010, 1'b0, 8'h00});
    vecs.push_back('{3'b100, 3'b100, {3'd2, 3'd0, 3'd0}, {8'h3C, 8'h00, 8'h00}, 3'b100, 1'b1, 8'h00});
    for (int r = 0; r < 2; r++) begin
      vecs.push_back('{3'b111, 3'b000, {3'd7, 3'd5, 3'd2}, 24'h0, 3'b001, 1'b0, 8'h3C});
      vecs.push_back('{3'b111, 3'b000, {3'd7, 3'd5, 3'd2}, 24'h0, 3'b010, 1'b0, 8'hA5});
      vecs.push_back('{3'b111, 3'b000, {3'd7, 3'd5, 3'd2}, 24'h0, 3'b100, 1'b0, 8'h00});
    end
    vecs.push_back('{3'b010, 3'b000, {3'd0, 3'd5, 3'd0}, 24'h0,                   3'b010, 1'b0, 8'hA5});
    vecs.push_back('{3'b001, 3'b000, {3'd0, 3'd0, 3'd2}, 24'h0,                   3'b001, 1'b0, 8'h3C});
    vecs.push_back('{3'b101, 3'b000, {3'd7, 3'd0, 3'd2}, 24'h0,                   3'b100, 1'b0, 8'h00});
    vecs.push_back('{3'b011, 3'b011, {3'd0, 3'd6, 3'd1}, {8'h00, 8'h11, 8'h22}, 3'b001, 1'b1, 8'h00});
    vecs.push_back('{3'b011, 3'b011, {3'd0, 3'd6, 3'd1}, {8'h00, 8'h11, 8'h22}, 3'b010, 1'b1, 8'h00});
    vecs.push_back('{3'b111, 3'b000, {3'd1, 3'd6, 3'd1}, 24'h0,                   3'b100, 1'b0, 8'h22});

    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = DW'($urandom);
      m_regs[i] = rf_mem[i];
    end
    m_left = NREG;
    m_ptr = 0;
    rst = 1'b1;
    clear_req = 1'b0;
    drive('0, '0, '0, '0);

    // reset and initial clear
    settle();
    chk("rst_busy", clear_busy, 1);
    chk("rst_we", rf_we, 1);
    chk("rst_sel", rf_sel, 0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      settle();
      chk("clr_busy", clear_busy, 1);
      chk("clr_sel", rf_sel, i);
      chk("clr_gnt", bus.gnt, 0);
      advance();
    end
    settle();
    chk("clr_done", clear_busy, 0);
    advance();

    // directed vector table
    foreach (vecs[v]) begin
      drive(vecs[v].req, vecs[v].we, vecs[v].sel, vecs[v].wdata);
      settle();
      chk($sformatf("vec%0d_gnt", v), bus.gnt, vecs[v].exp_gnt);
      chk($sformatf("vec%0d_we", v), rf_we, vecs[v].exp_we);
      chk($sformatf("vec%0d_rdata", v), bus.rdata, vecs[v].exp_rdata);
      advance();
    end

    // clear request colliding with pending requests
    clear_req = 1'b1;
    drive(3'b011, 3'b000, {3'd0, 3'd2, 3'd5}, 24'h0);
    settle();
    chk("coll_gnt", bus.gnt, 0);
    chk("coll_we", rf_we, 0);
    chk("coll_busy", clear_busy, 0);
    advance();
    clear_req = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      settle();
      chk("coll_clr_sel", rf_sel, i);
      chk("coll_clr_gnt", bus.gnt, 0);
      chk("coll_clr_we", rf_we, 1);
      advance();
    end
    settle();
    chk("coll_g0", bus.gnt, 3'b001);
    chk("coll_r0", bus.rdata, 0);
    advance();
    drive(3'b010, 3'b000, {3'd0, 3'd2, 3'd5}, 24'h0);
    settle();
    chk("coll_g1", bus.gnt, 3'b010);
    chk("coll_r1", bus.rdata, 0);
    advance();
    for (int i = 0; i < NREG; i++) begin
      drive(3'b001, 3'b000, {6'd0, 3'(i)}, 24'h0);
      settle();
      chk("zero_gnt", bus.gnt, 3'b001);
      chk("zero_rd", bus.rdata, 0);
      advance();
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      clear_req = ($urandom_range(0, 39) == 0);
      drive(N'($urandom_range(0, 7)), N'($urandom_range(0, 7)),
            (N*RB)'($urandom), (N*DW)'($urandom));
      settle();
      advance();
    end
    clear_req = 1'b0;
    drive('0, '0, '0, '0);

    // reset in the middle of a clear
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("mid_sel", rf_sel, i);
      advance();
    end
    rst = 1'b1;
    settle();
    chk("mid_rst_sel", rf_sel, 0);
    chk("mid_rst_busy", clear_busy, 1);
    advance();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      settle();
      chk("mid_re_busy", clear_busy, 1);
      chk("mid_re_sel", rf_sel, i);
      advance();
    end
    settle();
    chk("mid_done", clear_busy, 0);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
